// File: rtl/gppcu_alu_mul_seq.sv
// Shift-add multiplier sequencer that borrows the shared GPPCU ALU for the accumulate step.
// Optional signed support (magnitude load + final negate) with GPPCU_MUL_SIGNED_EN.
module gppcu_alu_mul_seq #(
   parameter int unsigned BW         = 32,
   parameter logic [3:0]  ALU_OP_NOP = 4'h0,
   parameter logic [3:0]  ALU_OP_ADI = 4'h1
) (
   input  logic            iCLK,
   input  logic            iRSTn,
   input  logic            iSTART,
   input  logic [BW-1:0]   iA,
   input  logic [BW-1:0]   iB,
`ifdef GPPCU_MUL_SIGNED_EN
   input  logic            iSIGNED,
`endif
   output logic            oBUSY,
   output logic            oDONE,
   output logic [2*BW-1:0] oPROD,
   output logic            oALU_REQ,
   input  logic            iALU_GNT,
   output logic [3:0]      oALU_OP,
   output logic [BW-1:0]   oALU_A,
   output logic [BW-1:0]   oALU_B,
   input  logic [BW-1:0]   iALU_Q,
   input  logic            iALU_C
);

   localparam int unsigned CW = $clog2(BW + 1);
   localparam int unsigned PW = 2 * BW;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADD   = 3'd1,
      S_SHIFT = 3'd2,
      S_DONE  = 3'd3
`ifdef GPPCU_MUL_SIGNED_EN
      , S_FIX = 3'd4
`endif
   } state_t;

   state_t          r_state;
   logic [BW-1:0]   r_m;
   logic [BW-1:0]   r_p_hi;
   logic [BW-1:0]   r_p_lo;
   logic            r_cy;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;
   logic            r_done;
   logic            r_alu_req;
   logic [3:0]      r_alu_op;
   logic [PW-1:0]   r_prod;

   state_t          w_state_nxt;
   logic [BW-1:0]   w_m_nxt;
   logic [BW-1:0]   w_p_hi_nxt;
   logic [BW-1:0]   w_p_lo_nxt;
   logic            w_cy_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_busy_nxt;
   logic            w_done_nxt;
   logic            w_alu_req_nxt;
   logic [3:0]      w_alu_op_nxt;
   logic [PW-1:0]   w_prod_nxt;
   logic [BW-1:0]   w_a_ld;
   logic [BW-1:0]   w_b_ld;
   state_t          w_last_state;

   // Operand load: magnitudes when a signed multiply is requested
`ifdef GPPCU_MUL_SIGNED_EN
   logic            r_sign;
   logic            w_sign_nxt;
   logic            w_neg_a;
   logic            w_neg_b;
   logic [PW-1:0]   w_prod_neg;

   assign w_neg_a      = iSIGNED & iA[BW-1];
   assign w_neg_b      = iSIGNED & iB[BW-1];
   assign w_a_ld       = w_neg_a ? (~iA + BW'(1)) : iA;
   assign w_b_ld       = w_neg_b ? (~iB + BW'(1)) : iB;
   assign w_prod_neg   = ~{r_p_hi, r_p_lo} + PW'(1);
   assign w_last_state = S_FIX;
`else
   assign w_a_ld       = iA;
   assign w_b_ld       = iB;
   assign w_last_state = S_DONE;
`endif

   // Next-state and datapath update
   always_comb begin
      w_state_nxt = r_state;
      w_m_nxt     = r_m;
      w_p_hi_nxt  = r_p_hi;
      w_p_lo_nxt  = r_p_lo;
      w_cy_nxt    = r_cy;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      w_prod_nxt  = r_prod;
`ifdef GPPCU_MUL_SIGNED_EN
      w_sign_nxt  = r_sign;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (iSTART) begin
               w_m_nxt     = w_a_ld;
               w_p_lo_nxt  = w_b_ld;
               w_p_hi_nxt  = '0;
               w_cy_nxt    = 1'b0;
               w_cnt_nxt   = CW'(BW);
`ifdef GPPCU_MUL_SIGNED_EN
               w_sign_nxt  = w_neg_a ^ w_neg_b;
`endif
               w_state_nxt = w_b_ld[0] ? S_ADD : S_SHIFT;
            end
         end
         S_ADD: begin
            if (iALU_GNT) begin
               w_cy_nxt    = iALU_C;
               w_p_hi_nxt  = iALU_Q;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_cy_nxt   = 1'b0;
            w_p_hi_nxt = {r_cy, r_p_hi[BW-1:1]};
            w_p_lo_nxt = {r_p_hi[0], r_p_lo[BW-1:1]};
            w_cnt_nxt  = r_cnt - CW'(1);
            // r_p_lo[1] becomes the new multiplier LSB after this shift
            if (r_cnt == CW'(1)) begin
               w_state_nxt = w_last_state;
            end else if (r_p_lo[1]) begin
               w_state_nxt = S_ADD;
            end else begin
               w_state_nxt = S_SHIFT;
            end
         end
`ifdef GPPCU_MUL_SIGNED_EN
         S_FIX: begin
            if (r_sign) begin
               {w_p_hi_nxt, w_p_lo_nxt} = w_prod_neg;
            end
            w_state_nxt = S_DONE;
         end
`endif
         S_DONE: begin
            w_prod_nxt  = {r_p_hi, r_p_lo};
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      w_busy_nxt    = (w_state_nxt != S_IDLE);
      w_alu_req_nxt = (w_state_nxt == S_ADD);
      w_alu_op_nxt  = w_alu_req_nxt ? ALU_OP_ADI : ALU_OP_NOP;
   end

   // State and output registers
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         r_state   <= S_IDLE;
         r_m       <= '0;
         r_p_hi    <= '0;
         r_p_lo    <= '0;
         r_cy      <= 1'b0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_alu_req <= 1'b0;
         r_alu_op  <= ALU_OP_NOP;
         r_prod    <= '0;
`ifdef GPPCU_MUL_SIGNED_EN
         r_sign    <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_m       <= w_m_nxt;
         r_p_hi    <= w_p_hi_nxt;
         r_p_lo    <= w_p_lo_nxt;
         r_cy      <= w_cy_nxt;
         r_cnt     <= w_cnt_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_alu_req <= w_alu_req_nxt;
         r_alu_op  <= w_alu_op_nxt;
         r_prod    <= w_prod_nxt;
`ifdef GPPCU_MUL_SIGNED_EN
         r_sign    <= w_sign_nxt;
`endif
      end
   end

   assign oBUSY    = r_busy;
   assign oDONE    = r_done;
   assign oPROD    = r_prod;
   assign oALU_REQ = r_alu_req;
   assign oALU_OP  = r_alu_op;
   assign oALU_A   = r_p_hi;
   assign oALU_B   = r_m;

endmodule

// File: tb/tb_gppcu_alu_mul_seq.sv
// Directed bench for gppcu_alu_mul_seq (BW=8) with a behavioural adder standing in for the ALU.
module tb_gppcu_alu_mul_seq;

   localparam int unsigned BW = 8;
`ifdef GPPCU_MUL_SIGNED_EN
   localparam int FIX_LAT = 1;
`else
   localparam int FIX_LAT = 0;
`endif

   logic            iCLK;
   logic            iRSTn;
   logic            iSTART;
   logic [BW-1:0]   iA;
   logic [BW-1:0]   iB;
`ifdef GPPCU_MUL_SIGNED_EN
   logic            iSIGNED;
`endif
   logic            oBUSY;
   logic            oDONE;
   logic [2*BW-1:0] oPROD;
   logic            oALU_REQ;
   logic            alu_gnt;
   logic [3:0]      oALU_OP;
   logic [BW-1:0]   oALU_A;
   logic [BW-1:0]   oALU_B;
   logic [BW-1:0]   alu_q;
   logic            alu_c;

   int n_checks = 0;
   int n_errors = 0;
   int n_gnt_tot = 0;
   int n_req_tot = 0;
   int n_done_tot = 0;
   int n_op_bad = 0;

   gppcu_alu_mul_seq #(.BW(BW)) dut (
      .iCLK     (iCLK),
      .iRSTn    (iRSTn),
      .iSTART   (iSTART),
      .iA       (iA),
      .iB       (iB),
`ifdef GPPCU_MUL_SIGNED_EN
      .iSIGNED  (iSIGNED),
`endif
      .oBUSY    (oBUSY),
      .oDONE    (oDONE),
      .oPROD    (oPROD),
      .oALU_REQ (oALU_REQ),
      .iALU_GNT (alu_gnt),
      .oALU_OP  (oALU_OP),
      .oALU_A   (oALU_A),
      .oALU_B   (oALU_B),
      .iALU_Q   (alu_q),
      .iALU_C   (alu_c)
   );

   // ADI model: A + B with carry-out
   assign {alu_c, alu_q} = {1'b0, oALU_A} + {1'b0, oALU_B};

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   always @(posedge iCLK) begin
      if (oALU_REQ && alu_gnt) n_gnt_tot++;
      if (oALU_REQ) n_req_tot++;
      if (oDONE) n_done_tot++;
   end

   always @(negedge iCLK) begin
      if (iRSTn && (oALU_OP != (oALU_REQ ? 4'h1 : 4'h0))) n_op_bad++;
   end

   task automatic chk(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   // Start one multiply, optionally stalling the grant and re-pulsing start mid-run
   task automatic run_mul(input logic [BW-1:0] a, input logic [BW-1:0] b, input int stall,
                          input int restart_at, output int lat, output int n_gnt, output int n_req);
      int stalled;
      int gnt0;
      int req0;
      stalled = 0;
      gnt0 = n_gnt_tot;
      req0 = n_req_tot;
      alu_gnt = (stall == 0);
      iA = a;
      iB = b;
      iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      lat = 0;
      chk("busy_after_start", int'(oBUSY), 1);
      while (oDONE !== 1'b1 && lat < 200) begin
         if (oALU_REQ && !alu_gnt) begin
            stalled++;
            if (stalled > stall) alu_gnt = 1'b1;
         end
         if (lat == restart_at) begin
            iSTART = 1'b1;
            iA = 8'h01;
            iB = 8'h01;
         end else begin
            iSTART = 1'b0;
         end
         tick();
         lat++;
      end
      iSTART = 1'b0;
      alu_gnt = 1'b1;
      chk("done_seen", int'(oDONE), 1);
      chk("busy_at_done", int'(oBUSY), 0);
      n_gnt = n_gnt_tot - gnt0;
      n_req = n_req_tot - req0;
   endtask

   initial begin
      int lat;
      int ng;
      int nr;
      int d0;
      iRSTn = 1'b0;
      iSTART = 1'b0;
      iA = '0;
      iB = '0;
      alu_gnt = 1'b1;
`ifdef GPPCU_MUL_SIGNED_EN
      iSIGNED = 1'b0;
`endif
      repeat (2) tick();
      iRSTn = 1'b1;
      tick();
      chk("rst_busy", int'(oBUSY), 0);
      chk("rst_done", int'(oDONE), 0);
      chk("rst_req", int'(oALU_REQ), 0);
      chk("rst_prod", int'(oPROD), 0);
      chk("rst_op", int'(oALU_OP), 0);
      chk("rst_alu_a", int'(oALU_A), 0);

      // 3*5
      run_mul(8'd3, 8'd5, 0, -1, lat, ng, nr);
      chk("t1_prod", int'(oPROD), 'h000F);
      chk("t1_lat", lat, 11 + FIX_LAT);
      chk("t1_gnt", ng, 2);
      tick();
      chk("t1_done_pulse", int'(oDONE), 0);
      chk("t1_prod_hold", int'(oPROD), 'h000F);

      // 0xFF*0xFF exercises the carry path
      run_mul(8'hFF, 8'hFF, 0, -1, lat, ng, nr);
      chk("t2_prod", int'(oPROD), 'hFE01);
      chk("t2_lat", lat, 17 + FIX_LAT);
      chk("t2_gnt", ng, 8);
      tick();

      // Reset mid-run aborts with no done
      iA = 8'hFF;
      iB = 8'hFF;
      iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      repeat (5) tick();
      chk("t5_busy_mid", int'(oBUSY), 1);
      d0 = n_done_tot;
      iRSTn = 1'b0;
      #1;
      chk("t5_rst_busy", int'(oBUSY), 0);
      chk("t5_rst_prod", int'(oPROD), 0);
      chk("t5_rst_req", int'(oALU_REQ), 0);
      tick();
      iRSTn = 1'b1;
      repeat (20) tick();
      chk("t5_no_done", n_done_tot - d0, 0);
      chk("t5_idle", int'(oBUSY), 0);
      run_mul(8'd2, 8'd3, 0, -1, lat, ng, nr);
      chk("t5_prod", int'(oPROD), 'h0006);
      chk("t5_lat", lat, 11 + FIX_LAT);
      tick();

      // Grant held low for 5 cycles
      run_mul(8'd7, 8'd1, 5, -1, lat, ng, nr);
      chk("t3_prod", int'(oPROD), 'h0007);
      chk("t3_lat", lat, 15 + FIX_LAT);
      chk("t3_gnt", ng, 1);
      chk("t3_req_cycles", nr, 6);
      tick();

      // Zero multiplier, second start ignored
      d0 = n_done_tot;
      run_mul(8'hAB, 8'h00, 0, 3, lat, ng, nr);
      chk("t4_prod", int'(oPROD), 0);
      chk("t4_lat", lat, 9 + FIX_LAT);
      chk("t4_req_cycles", nr, 0);
      repeat (4) tick();
      chk("t4_no_queue_busy", int'(oBUSY), 0);
      chk("t4_one_done", n_done_tot - d0, 1);
      chk("t4_prod_hold", int'(oPROD), 0);

`ifdef GPPCU_MUL_SIGNED_EN
      iSIGNED = 1'b1;
      run_mul(8'hFD, 8'h05, 0, -1, lat, ng, nr);
      chk("t6_neg_prod", int'(oPROD), 'hFFF1);
      chk("t6_neg_lat", lat, 12);
      tick();
      run_mul(8'h80, 8'h80, 0, -1, lat, ng, nr);
      chk("t6_min_prod", int'(oPROD), 'h4000);
      chk("t6_min_lat", lat, 11);
      iSIGNED = 1'b0;
      tick();
`endif

      chk("alu_op_encoding", n_op_bad, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
